// File: rtl/converter_if.sv
// Handshake bundle for the number-format converter.
// The master drives samples; the slave returns registered results.
interface converter_if #(
   parameter int WIDTH = 8
);
   logic                    in_valid;
   logic                    flag;
   logic signed [WIDTH-1:0] in;
   logic signed [WIDTH-1:0] out;
   logic                    out_valid;
   logic                    ovf;

   modport master (
      output in_valid, flag, in,
      input  out, out_valid, ovf
   );

   modport slave (
      input  in_valid, flag, in,
      output out, out_valid, ovf
   );
endinterface

// File: rtl/converter.sv
// Registered two's-complement <-> sign-magnitude converter, latency 1.
// Define CONVERTER_SAT_EN to saturate the two's-complement minimum.
module converter #(
   parameter int WIDTH = 8
) (
   input logic       clk,
   input logic       rst_n,
   converter_if.slave bus
);

   logic             sign;
   logic             is_min;
   logic [WIDTH-2:0] mag;
   logic [WIDTH-2:0] neg;
   logic [WIDTH-1:0] conv;
   logic             conv_ovf;

   // Negating the magnitude field is its own inverse in both directions
   always_comb begin
      sign     = bus.in[WIDTH-1];
      mag      = bus.in[WIDTH-2:0];
      neg      = -mag;
      is_min   = sign && (mag == '0);
      conv     = bus.in;
      conv_ovf = 1'b0;
      unique case (1'b1)
         !sign: conv = bus.in;
         is_min && !bus.flag: conv = '0;
         is_min && bus.flag: begin
`ifdef CONVERTER_SAT_EN
            conv     = {WIDTH{1'b1}};
            conv_ovf = 1'b1;
`else
            conv     = bus.in;
`endif
         end
         default: conv = {1'b1, neg};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
         bus.ovf       <= 1'b0;
      end else begin
         bus.out_valid <= bus.in_valid;
         if (bus.in_valid) begin
            bus.out <= conv;
            bus.ovf <= conv_ovf;
         end
      end
   end

endmodule

// File: tb/tb_converter.sv
// Randomized and directed bench for converter against an arithmetic
// reference model of the two number formats.
module tb_converter;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [7:0] m_out;
   logic       m_ovf;
   logic       m_vld;

   converter_if #(.WIDTH(8)) bus ();

   converter #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {ovf, out} computed from signed values, not from bit tricks
   function automatic logic [8:0] ref_conv(bit f, logic [7:0] d);
      int v;
      if (f) begin
         v = int'($signed(d));
         if (v >= 0) return {1'b0, d};
         if (v == -128) begin
`ifdef CONVERTER_SAT_EN
            return 9'h1FF;
`else
            return 9'h080;
`endif
         end
         return {1'b0, 8'h80 | 8'(-v)};
      end
      v = d[7] ? -int'(d[6:0]) : int'(d[6:0]);
      return {1'b0, 8'(v)};
   endfunction

   task automatic tick();
      logic [8:0] r;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_out = '0;
         m_ovf = 1'b0;
         m_vld = 1'b0;
      end else begin
         m_vld = bus.in_valid;
         if (bus.in_valid) begin
            r     = ref_conv(bus.flag, bus.in);
            m_out = r[7:0];
            m_ovf = r[8];
         end
      end
      check("out", bus.out, m_out);
      check("out_valid", {7'd0, bus.out_valid}, {7'd0, m_vld});
      check("ovf", {7'd0, bus.ovf}, {7'd0, m_ovf});
   endtask

   task automatic send(bit f, logic [7:0] d, logic [7:0] exp, string tag);
      bus.in_valid = 1'b1;
      bus.flag     = f;
      bus.in       = d;
      tick();
      check(tag, bus.out, exp);
   endtask

   logic [7:0] d1 [4] = '{8'hF5, 8'h85, 8'hB5, 8'h75};
   logic [7:0] e1 [4] = '{8'h8B, 8'hFB, 8'hCB, 8'h75};
   logic [7:0] d0 [4] = '{8'h8B, 8'hFB, 8'h55, 8'h80};
   logic [7:0] e0 [4] = '{8'hF5, 8'h85, 8'h55, 8'h00};

   initial begin
      total = 0;
      bad   = 0;
      m_out = '0;
      m_ovf = 1'b0;
      m_vld = 1'b0;

      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.flag     = 1'b1;
      bus.in       = 8'h55;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_out", bus.out, 8'h00);
      end
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) send(1'b1, d1[i], e1[i], "dir1");
      for (int i = 0; i < 4; i++) send(1'b0, d0[i], e0[i], "dir0");

`ifdef CONVERTER_SAT_EN
      send(1'b1, 8'h80, 8'hFF, "min");
      check("min_ovf", {7'd0, bus.ovf}, 8'h01);
`else
      send(1'b1, 8'h80, 8'h80, "min");
      check("min_ovf", {7'd0, bus.ovf}, 8'h00);
`endif

      send(1'b1, 8'hF3, 8'h8D, "gap_a");
      bus.in_valid = 1'b0;
      bus.in       = 8'h12;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("gap_hold", bus.out, 8'h8D);
      end
      send(1'b0, 8'h8F, 8'hF1, "gap_b");

      for (int i = 0; i < 6; i++) send(i[0], 8'hB0, 8'hD0, "alt");

      bus.in_valid = 1'b1;
      bus.in       = 8'h33;
      rst_n        = 1'b0;
      tick();
      check("rst_mid", bus.out, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         rst_n        = ($urandom_range(0, 29) != 0);
         bus.in_valid = ($urandom_range(0, 3) != 0);
         bus.flag     = 1'($urandom);
         case ($urandom_range(0, 7))
            0: bus.in = 8'h80;
            1: bus.in = 8'h00;
            2: bus.in = 8'hFF;
            3: bus.in = 8'h7F;
            default: bus.in = 8'($urandom);
         endcase
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
